// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : MIPS instruction-fetch stage plus IF/ID pipeline register.
//             Owns the PC, fetches from instruction memory over a single-
//             outstanding req/ack handshake, and presents {pc, instr, valid}
//             to decode. Accepts a taken branch/jump redirect from decode and
//             squashes wrong-path fetches, including a response still in
//             flight.
//  Ports    : i_clk, i_rst          clock / async active-high reset
//             i_stall               hold IF/ID (decode load-use stall)
//             i_change_pc,
//             i_target_pc           taken redirect and its target PC
//             o_imem_req,
//             o_imem_addr           registered imem request / address
//             i_imem_ack,
//             i_imem_data           imem response and instruction word
//             o_id_pc, o_id_instr,
//             o_id_valid            IF/ID register contents
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
   parameter int                  PC_WIDTH = 32,
   parameter int                  IWIDTH   = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter logic [PC_WIDTH-1:0] PC_INC   = 1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_stall,
   input  logic                i_change_pc,
   input  logic [PC_WIDTH-1:0] i_target_pc,
   output logic                o_imem_req,
   output logic [PC_WIDTH-1:0] o_imem_addr,
   input  logic                i_imem_ack,
   input  logic [IWIDTH-1:0]   i_imem_data,
   output logic [PC_WIDTH-1:0] o_id_pc,
   output logic [IWIDTH-1:0]   o_id_instr,
   output logic                o_id_valid
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_HOLD   = 2'd2;
   localparam logic [1:0] S_SQUASH = 2'd3;

   logic [1:0]          state_q,      state_d;
   logic [PC_WIDTH-1:0] pc_q,         pc_d;
   logic                req_q,        req_d;
   logic [PC_WIDTH-1:0] addr_q,       addr_d;
   logic [PC_WIDTH-1:0] id_pc_q,      id_pc_d;
   logic [IWIDTH-1:0]   id_instr_q,   id_instr_d;
   logic                id_valid_q,   id_valid_d;
   // The skid is only meaningful while in HOLD; leaving HOLD empties it.
   logic [PC_WIDTH-1:0] skid_pc_q,    skid_pc_d;
   logic [IWIDTH-1:0]   skid_instr_q, skid_instr_d;

   logic                xfer;
   logic [PC_WIDTH-1:0] pc_next;

   assign xfer    = req_q & i_imem_ack;
   assign pc_next = pc_q + PC_INC;   // wraps modulo 2^PC_WIDTH

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_d        = req_q;
      addr_d       = addr_q;
      id_pc_d      = id_pc_q;
      id_instr_d   = id_instr_q;
      id_valid_d   = id_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;

      case (state_q)
         S_IDLE: begin
            // Redirects are ignored here; the first fetch is always RESET_PC.
            state_d = S_FETCH;
            req_d   = 1'b1;
            addr_d  = pc_q;
         end

         S_FETCH: begin
            if (i_change_pc) begin
               pc_d       = i_target_pc;
               id_valid_d = 1'b0;
               id_instr_d = '0;
               if (xfer) begin
                  // Response arrived together with the redirect: drop it
                  // and start the target fetch right away.
                  addr_d  = i_target_pc;
                  state_d = S_FETCH;
               end else begin
                  // Address must not change mid-request; drain it first.
                  state_d = S_SQUASH;
               end
            end else if (xfer && !i_stall) begin
               id_pc_d    = pc_q;
               id_instr_d = i_imem_data;
               id_valid_d = 1'b1;
               pc_d       = pc_next;
               addr_d     = pc_next;
            end else if (xfer) begin
               skid_pc_d    = pc_q;
               skid_instr_d = i_imem_data;
               req_d        = 1'b0;
               state_d      = S_HOLD;
            end else if (!i_stall) begin
               id_valid_d = 1'b0;
               id_instr_d = '0;
            end
         end

         S_HOLD: begin
            if (i_change_pc) begin
               pc_d       = i_target_pc;
               id_valid_d = 1'b0;
               id_instr_d = '0;
               req_d      = 1'b1;
               addr_d     = i_target_pc;
               state_d    = S_FETCH;
            end else if (!i_stall) begin
               id_pc_d    = skid_pc_q;
               id_instr_d = skid_instr_q;
               id_valid_d = 1'b1;
               pc_d       = pc_next;
               req_d      = 1'b1;
               addr_d     = pc_next;
               state_d    = S_FETCH;
            end
         end

         S_SQUASH: begin
            // IF/ID was bubbled on entry and stays a bubble until real data.
            id_valid_d = 1'b0;
            id_instr_d = '0;
            if (i_change_pc) begin
               pc_d = i_target_pc;
            end
            if (xfer) begin
               // Wrong-path response consumed; fetch the latest target.
               addr_d  = i_change_pc ? i_target_pc : pc_q;
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         req_q        <= 1'b0;
         addr_q       <= '0;
         id_pc_q      <= '0;
         id_instr_q   <= '0;
         id_valid_q   <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         id_pc_q      <= id_pc_d;
         id_instr_q   <= id_instr_d;
         id_valid_q   <= id_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

   assign o_imem_req  = req_q;
   assign o_imem_addr = addr_q;
   assign o_id_pc     = id_pc_q;
   assign o_id_instr  = id_instr_q;
   assign o_id_valid  = id_valid_q;

endmodule
`default_nettype wire
